// File: rtl/md_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_LATENCY = MD_WIDTH + 3;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_PREP = 2'b01,
    MD_CALC = 2'b10,
    MD_FIX  = 2'b11
  } md_state_e;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/md_unit.sv
// Iterative mult/multu/div/divu unit owning the HI/LO pair; one result bit per CALC cycle.
module md_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  md_state_e          state, state_nxt;
  md_op_e             op_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc;
  logic               neg_res, neg_rem;
  logic [CW-1:0]      cnt;
  logic               done_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               is_div, is_sgn, div_zero;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     add_sum, sub_diff;
  logic [2*WIDTH:0]   shl;
  logic [2*WIDTH-1:0] acc_step, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div   = md_is_div(op_q);
  assign is_sgn   = md_is_signed(op_q);
  assign div_zero = is_div && (b_q == '0);
  assign a_abs    = (is_sgn && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_abs    = (is_sgn && b_q[WIDTH-1]) ? -b_q : b_q;

  // Multiply keeps the multiplier in the low half and shifts the partial product in from the top.
  // Divide keeps {remainder, dividend/quotient} and shifts left, setting a quotient bit on success.
  assign add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
  assign shl      = {acc, 1'b0};
  assign sub_diff = shl[2*WIDTH:WIDTH] - {1'b0, b_q};

  always_comb begin
    acc_step = acc;
    if (is_div) begin
      if (sub_diff[WIDTH]) acc_step = shl[2*WIDTH-1:0];
      else                 acc_step = {sub_diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      if (acc[0]) acc_step = {add_sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  assign prod_fix = neg_res ? -acc : acc;
  assign quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (start) state_nxt = MD_PREP;
      MD_PREP: state_nxt = div_zero ? MD_IDLE : MD_CALC;
      MD_CALC: if (cnt == CW'(ITER - 1)) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= MD_MULT;
      a_q     <= '0;
      b_q     <= '0;
      acc     <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      cnt     <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (hi_wr) hi_q <= wr_data;
          if (lo_wr) lo_q <= wr_data;
          if (start) begin
            op_q <= md_op_e'(md_op);
            a_q  <= op_a;
            b_q  <= op_b;
          end
        end
        MD_PREP: begin
          acc     <= {{WIDTH{1'b0}}, a_abs};
          b_q     <= b_abs;
          neg_res <= is_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          neg_rem <= is_sgn && a_q[WIDTH-1];
          cnt     <= '0;
          done_q  <= div_zero;
          dbz_q   <= div_zero;
        end
        MD_CALC: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        MD_FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != MD_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: model-driven scoreboard of {div_by_zero, hi, lo} per operation.
module tb_md_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, hi_wr, lo_wr;
  logic [1:0]   md_op;
  logic [W-1:0] op_a, op_b, wr_data;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  md_unit dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op),
    .op_a(op_a), .op_b(op_b), .hi_wr(hi_wr), .lo_wr(lo_wr),
    .wr_data(wr_data), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: returns {div_by_zero, hi, lo}
  function automatic logic [2*W:0] model(input md_op_e op, input logic [W-1:0] a, b,
                                         input logic [W-1:0] h, l);
    longint       sa, sb;
    logic [63:0]  p;
    logic [W-1:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MULT: begin
        p = 64'(sa * sb);
        return {1'b0, p};
      end
      MD_MULTU: begin
        p = 64'(a) * 64'(b);
        return {1'b0, p};
      end
      MD_DIV: begin
        if (b == '0) return {1'b1, h, l};
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {1'b0, r, q};
      end
      default: begin
        if (b == '0) return {1'b1, h, l};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  // driver: issue one op, optionally pulse hi_wr at cycle wr_k after start, collect result
  task automatic run_op(input md_op_e op, input logic [W-1:0] a, b, input int wr_k);
    logic [2*W:0] e, got;
    int lat;
    bit seen;
    e = model(op, a, b, m_hi, m_lo);
    exp_q.push_back(e);
    lat = e[2*W] ? 2 : MD_LATENCY;
    @(negedge clk);
    start = 1'b1; md_op = op; op_a = a; op_b = b;
    seen = 1'b0;
    for (int k = 1; k <= MD_LATENCY + 10 && !seen; k++) begin
      @(negedge clk);
      start = 1'b0;
      hi_wr = 1'b0;
      if (k == 1 && lat > 2) check("busy_after_issue", busy, 1);
      if (wr_k > 0 && k == wr_k + 1) check("hi_wr_ignored_busy", hi, m_hi);
      if (wr_k > 0 && k == wr_k) begin
        hi_wr = 1'b1;
        wr_data = 32'h0000_1234;
      end
      if (done) begin
        seen = 1'b1;
        got = exp_q.pop_front();
        check("latency", k, lat);
        check("busy_at_done", busy, 0);
        check("div_by_zero", div_by_zero, got[2*W]);
        check("hi", hi, got[2*W-1:W]);
        check("lo", lo, got[W-1:0]);
        m_hi = got[2*W-1:W];
        m_lo = got[W-1:0];
      end
    end
    hi_wr = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    @(negedge clk);
    check("done_one_pulse", done, 0);
  endtask

  task automatic write_reg(input bit is_hi, input logic [W-1:0] d);
    @(negedge clk);
    hi_wr = is_hi; lo_wr = !is_hi; wr_data = d;
    @(negedge clk);
    hi_wr = 1'b0; lo_wr = 1'b0;
    if (is_hi) m_hi = d; else m_lo = d;
  endtask

  task automatic abort_mid_calc();
    int done_seen;
    @(negedge clk);
    start = 1'b1; md_op = MD_MULTU; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < MD_LATENCY + 5; k++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0;
    md_op = 2'b00; op_a = '0; op_b = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst = 1'b1;

    run_op(MD_MULT, 32'hFFFF_FFFF, 32'd2, 0);
    check("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    check("plan_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    check("plan_div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(MD_DIVU, 32'd7, 32'd2, 0);
    check("plan_divu", {hi, lo}, 64'h0000_0001_0000_0003);
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("plan_div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    write_reg(1'b1, 32'h11);
    write_reg(1'b0, 32'h22);
    check("preload", {hi, lo}, 64'h0000_0011_0000_0022);
    run_op(MD_DIVU, 32'd5, 32'd0, 0);
    check("plan_div0", {hi, lo}, 64'h0000_0011_0000_0022);

    run_op(MD_MULTU, 32'd6, 32'd7, 10);
    check("plan_after_hi_wr", {hi, lo}, 64'd42);
    write_reg(1'b0, 32'hABCD);
    check("lo_wr_after_done", lo, 32'hABCD);

    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra, rb;
      md_op_e rop;
      rop = md_op_e'(2'($urandom_range(0, 3)));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = '0;
        1:       rb = W'($urandom_range(1, 15));
        2:       rb = -W'($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_op(rop, ra, rb, 0);
    end

    abort_mid_calc();
    run_op(MD_MULTU, 32'd3, 32'd4, 0);
    check("plan_after_abort", {hi, lo}, 64'd12);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the multi-cycle MIPS core.
- Executes mult, multu, div and divu. Services mthi, mtlo, mfhi and mflo.
- Sits beside the ALU, downstream of the register-file read latches. The core's control FSM issues operations and stalls on busy.
- HI/LO are read combinationally by the core's rf write-data mux.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each; only 32 is supported by the core.
- ITER, WIDTH, number of CALC iterations (one result bit per cycle).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  issue the operation in md_op; sampled only in IDLE.
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu.
- op_a  in  WIDTH  rs value (multiplicand / dividend).
- op_b  in  WIDTH  rt value (multiplier / divisor).
- hi_wr  in  1  mthi strobe.
- lo_wr  in  1  mtlo strobe.
- wr_data  in  WIDTH  data for mthi/mtlo.
- busy  out  1  operation in flight; the core stalls any MD instruction while busy=1.
- done  out  1  one-cycle pulse: operation finished; HI/LO hold the new values in this cycle.
- div_by_zero  out  1  one-cycle pulse with done when a div/divu had op_b=0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; hi=lo=0; busy=done=div_by_zero=0.
  - All internal accumulators are cleared.
  - Reset mid-operation aborts immediately; no done pulse follows.
- States: IDLE -> PREP -> CALC(ITER cycles) -> FIX -> IDLE.
- IDLE, start=1 in cycle N:
  - Latch op_a, op_b and md_op.
  - busy=1 from N+1.
- PREP (N+1):
  - Signed ops (mult, div): take magnitudes of the operands; record result sign and dividend sign.
  - Unsigned ops: use operands as-is.
  - div/divu with op_b=0: return to IDLE. done=1 and div_by_zero=1 at N+2, busy=0 at N+2, HI/LO unchanged.
- CALC (N+2 .. N+1+ITER):
  - Multiply: shift-add on a 2*WIDTH accumulator, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
  - An iteration counter counts 0..ITER-1 and wraps to FIX.
- FIX (N+2+ITER):
  - Apply sign correction, then write HI/LO on the clock edge ending FIX.
  - mult/multu: HI = product[2W-1:W], LO = product[W-1:0].
  - div/divu: LO = quotient, HI = remainder.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
- Output timing: at N+3+ITER (N+35 for WIDTH=32), done=1 for one cycle, busy=0, and new HI/LO are visible.
- Signed overflow 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. No exception is raised.
- Arithmetic is modulo 2^(2W) for products. Signed product sign is the XOR of the operand signs; a zero product is never negated to nonzero.
- start while busy: ignored. The core must not issue it.
- hi_wr/lo_wr while busy: ignored.
- hi_wr/lo_wr in IDLE: register takes wr_data at the next edge. Both strobes may be asserted together.
- start together with hi_wr/lo_wr in IDLE: both honoured. The write lands first; the operation result overwrites it at FIX.
- mfhi/mflo need no handshake: hi/lo are plain register outputs. The core must not read them while busy=1.
- done and div_by_zero are registered and never asserted together with busy=1.

Decomposition:
- Shared package md_pkg:
  - md_op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU.
  - State encodings MD_IDLE, MD_PREP, MD_CALC, MD_FIX.
  - MD_LATENCY = WIDTH+3.
- No sub-module. The FSM, iteration counter, shared accumulator/remainder datapath and HI/LO registers fit in one module of roughly 200–250 lines.

Test Plan:
- mult op_a=0xFFFFFFFF op_b=2 -> done exactly 35 cycles after the start cycle, HI=0xFFFFFFFF, LO=0xFFFFFFFE. multu same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- div op_a=0xFFFFFFF9(-7) op_b=2 -> LO=0xFFFFFFFD(-3), HI=0xFFFFFFFF(-1). divu 7/2 -> LO=3, HI=1.
- div op_a=0x80000000 op_b=0xFFFFFFFF -> LO=0x80000000, HI=0, div_by_zero=0.
- Preload HI=0x11, LO=0x22, then divu 5/0 -> done=div_by_zero=1 two cycles after start, HI=0x11, LO=0x22 unchanged.
- hi_wr wr_data=0x1234 during CALC -> HI unchanged. After done, lo_wr wr_data=0xABCD -> LO=0xABCD next cycle.
- Drive rst=0 at the 10th CALC cycle of a multu -> busy=0, HI=LO=0 immediately, no done. A subsequent multu 3*4 -> LO=12, HI=0.
